// File: rtl/fetch_if_id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package    : fetch_if_id_stage_pkg
// Description: Shared types and constants for the fetch stage and the IF/ID
//              pipeline register (instruction width, NOP/HALT encodings,
//              fetch state encoding, PC increment helper).
// Revision   : 1.0 - initial release
// ============================================================================
package fetch_if_id_stage_pkg;

  localparam int unsigned c_INSTR_W   = 16;
  localparam logic [15:0] c_NOP_INSTR = 16'h0800;
  localparam logic [4:0]  c_HALT_OP   = 5'b00000;
  localparam logic [15:0] c_PC_STEP   = 16'h0002;

  typedef logic [c_INSTR_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // PC arithmetic is modulo 2^16; 16'hFFFE + 2 wraps to 16'h0000.
  function automatic word_t pc_inc(input word_t pc);
    return pc + c_PC_STEP;
  endfunction

  function automatic logic is_halt(input word_t instr);
    return instr[15:11] == c_HALT_OP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if_id_stage_skid.sv
`default_nettype none
// ============================================================================
// Module     : fetch_if_id_stage_skid
// Description: One-entry holding buffer for an instruction word and its PC+2.
//              Captures a read that completes while decode is stalled so the
//              word is not lost. Priority: clear > load > drain.
// Ports      : clk, rst       - clock, async active-high reset
//              i_load         - capture i_instr / i_pc2, mark valid
//              i_drain        - entry consumed, mark empty
//              i_clear        - invalidate (pipeline flush)
//              i_instr, i_pc2 - data to capture
//              o_valid, o_instr, o_pc2 - buffered entry
// Revision   : 1.0 - initial release
// ============================================================================
module fetch_if_id_stage_skid
  import fetch_if_id_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  logic  i_drain,
  input  logic  i_clear,
  input  word_t i_instr,
  input  word_t i_pc2,
  output logic  o_valid,
  output word_t o_instr,
  output word_t o_pc2
);

  logic  r_valid;
  word_t r_instr;
  word_t r_pc2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc2   <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc2   <= i_pc2;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc2   = r_pc2;

endmodule
`default_nettype wire

// File: rtl/fetch_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module     : fetch_if_id_stage
// Description: Fetch stage plus IF/ID pipeline register. Owns the PC, issues
//              16-bit reads to the instruction cache over a done handshake and
//              presents instr/pc2/is_rst/valid to the decoder. Handles decode
//              stalls (with a one-entry skid), redirects and HALT.
// Ports      : clk, rst                 - clock, async active-high reset
//              imem_addr/imem_rd        - read request to instruction cache
//              imem_rdata/imem_done     - read completion from cache
//              stall_ID                 - hold IF/ID and PC
//              redirect/redirect_pc     - flush and restart at target
//              halt_ID                  - stop fetching
//              instr_IF_ID, pc2_IF_ID, is_rst_IF_ID, valid_IF_ID - to decoder
// Revision   : 1.0 - initial release
// ============================================================================
module fetch_if_id_stage
  import fetch_if_id_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = c_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        stall_ID,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_ID,
  output logic [15:0] instr_IF_ID,
  output logic [15:0] pc2_IF_ID,
  output logic        is_rst_IF_ID,
  output logic        valid_IF_ID
);

  state_e r_state;
  word_t  r_pc;
  word_t  r_drain_addr;
  word_t  r_instr;
  word_t  r_pc2;
  logic   r_is_rst;
  logic   r_valid;

  state_e w_state_nx;
  word_t  w_pc_nx;
  word_t  w_drain_addr_nx;
  word_t  w_pc_plus2;
  word_t  w_addr;
  logic   w_rd;
  logic   w_bubble;
  logic   w_latch;
  word_t  w_src_instr;
  word_t  w_src_pc2;
  logic   w_skid_load;
  logic   w_skid_drain;
  logic   w_skid_clear;
  logic   w_skid_valid;
  word_t  w_skid_instr;
  word_t  w_skid_pc2;

  assign w_pc_plus2 = pc_inc(r_pc);

  fetch_if_id_stage_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (w_skid_clear),
    .i_instr (imem_rdata),
    .i_pc2   (w_pc_plus2),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc2   (w_skid_pc2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_instr      <= NOP_INSTR;
      r_pc2        <= '0;
      r_is_rst     <= 1'b1;
      r_valid      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_drain_addr <= w_drain_addr_nx;
      if (w_bubble) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (w_latch) begin
        r_instr  <= w_src_instr;
        r_pc2    <= w_src_pc2;
        r_valid  <= 1'b1;
        r_is_rst <= 1'b0;
      end
    end
  end

  // Next-state / datapath control. Priority: redirect > stall > halt > advance.
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_drain_addr_nx = r_drain_addr;
    w_addr          = r_pc;
    w_rd            = 1'b0;
    w_bubble        = 1'b0;
    w_latch         = 1'b0;
    w_src_instr     = imem_rdata;
    w_src_pc2       = w_pc_plus2;
    w_skid_load     = 1'b0;
    w_skid_drain    = 1'b0;
    w_skid_clear    = 1'b0;

    case (r_state)
      ST_FETCH: begin
        // A buffered word must reach IF/ID before any new request; a pending
        // HALT also suppresses the request so nothing past it is fetched.
        w_rd = ~stall_ID & ~halt_ID & ~w_skid_valid;
        if (redirect) begin
          w_bubble     = 1'b1;
          w_skid_clear = 1'b1;
          w_pc_nx      = redirect_pc;
          // A request already accepted by the cache must be allowed to finish.
          if (w_rd && !imem_done) begin
            w_state_nx      = ST_DRAIN;
            w_drain_addr_nx = r_pc;
          end
        end else if (stall_ID) begin
          // hold everything
        end else if (halt_ID) begin
          w_bubble     = 1'b1;
          w_skid_clear = 1'b1;
          w_state_nx   = ST_HALTED;
        end else if (w_skid_valid) begin
          w_latch      = 1'b1;
          w_src_instr  = w_skid_instr;
          w_src_pc2    = w_skid_pc2;
          w_skid_drain = 1'b1;
          w_pc_nx      = w_pc_plus2;
        end else if (imem_done) begin
          w_latch = 1'b1;
          w_pc_nx = w_pc_plus2;
        end else begin
          w_bubble   = 1'b1;
          w_state_nx = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_rd = 1'b1;
        if (redirect) begin
          w_bubble     = 1'b1;
          w_skid_clear = 1'b1;
          w_pc_nx      = redirect_pc;
          if (imem_done) begin
            w_state_nx = ST_FETCH;
          end else begin
            w_state_nx      = ST_DRAIN;
            w_drain_addr_nx = r_pc;
          end
        end else if (stall_ID) begin
          // PC advances only when the skid entry is delivered.
          if (imem_done) begin
            w_skid_load = 1'b1;
            w_state_nx  = ST_FETCH;
          end
        end else if (imem_done) begin
          w_state_nx = ST_FETCH;
          if (halt_ID) begin
            w_bubble   = 1'b1;
            w_state_nx = ST_HALTED;
          end else begin
            w_latch = 1'b1;
            w_pc_nx = w_pc_plus2;
          end
        end else begin
          w_bubble = 1'b1;
        end
      end

      ST_DRAIN: begin
        // PC already holds the redirect target; finish the orphaned read.
        w_addr   = r_drain_addr;
        w_rd     = 1'b1;
        w_bubble = 1'b1;
        if (redirect) begin
          w_pc_nx = redirect_pc;
        end
        if (imem_done) begin
          w_state_nx = ST_FETCH;
        end
      end

      ST_HALTED: begin
        w_bubble = 1'b1;
        if (redirect) begin
          w_pc_nx    = redirect_pc;
          w_state_nx = ST_FETCH;
        end
      end

      default: begin
        w_state_nx = ST_FETCH;
      end
    endcase
  end

  assign imem_addr    = w_addr;
  assign imem_rd      = w_rd & ~rst;
  assign instr_IF_ID  = r_instr;
  assign pc2_IF_ID    = r_pc2;
  assign is_rst_IF_ID = r_is_rst;
  assign valid_IF_ID  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module     : tb_fetch_if_id_stage
// Description: Scoreboard bench for fetch_if_id_stage. Directed stimulus
//              pushes hand-computed IF/ID contents into a queue; a monitor
//              pops and compares whenever a new valid instruction appears.
//              Cache model: rdata = 0x4000 + addr/2, configurable miss count.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fetch_if_id_stage;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic        stall_ID;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_ID;
  logic [15:0] instr_IF_ID;
  logic [15:0] pc2_IF_ID;
  logic        is_rst_IF_ID;
  logic        valid_IF_ID;

  int          checks   = 0;
  int          failures = 0;
  int          miss_cnt = 0;
  logic        rd_seen;
  logic [15:0] addr_seen;
  exp_t        exp_q[$];

  fetch_if_id_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .imem_rdata   (imem_rdata),
    .imem_done    (imem_done),
    .stall_ID     (stall_ID),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt_ID      (halt_ID),
    .instr_IF_ID  (instr_IF_ID),
    .pc2_IF_ID    (pc2_IF_ID),
    .is_rst_IF_ID (is_rst_IF_ID),
    .valid_IF_ID  (valid_IF_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc2);
    exp_t e;
    e.instr = instr;
    e.pc2   = pc2;
    exp_q.push_back(e);
  endtask

  // One clock: called at a negedge with inputs already set.
  task automatic step();
    #1;
    imem_done  = imem_rd && (miss_cnt == 0);
    imem_rdata = imem_done ? (16'h4000 + {1'b0, imem_addr[15:1]}) : 16'hDEAD;
    rd_seen    = imem_rd;
    addr_seen  = imem_addr;
    @(posedge clk);
    if (rd_seen && miss_cnt > 0) miss_cnt--;
    @(negedge clk);
  endtask

  // Monitor: IF/ID can only change when stall_ID was low at the edge, so a
  // valid entry after such an edge is a freshly latched instruction.
  initial begin
    logic st;
    logic rs;
    exp_t e;
    forever begin
      @(posedge clk);
      st = stall_ID;
      rs = rst;
      #1;
      if (!rs && !rst && !st && valid_IF_ID) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got %h/%h expected none", instr_IF_ID, pc2_IF_ID);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", instr_IF_ID, e.instr);
          chk("sb_pc2", pc2_IF_ID, e.pc2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_ID = 0; redirect = 0; redirect_pc = 0; halt_ID = 0;
    imem_done = 0; imem_rdata = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_instr", instr_IF_ID, 16'h0800);
    chk("rst_pc2", pc2_IF_ID, 16'h0000);
    chk("rst_is_rst", {15'd0, is_rst_IF_ID}, 16'd1);
    chk("rst_valid", {15'd0, valid_IF_ID}, 16'd0);
    chk("rst_rd", {15'd0, imem_rd}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: all hits from reset
    push(16'h4000, 16'h0002);
    push(16'h4001, 16'h0004);
    step();
    chk("t1_addr0", addr_seen, 16'h0000);
    chk("t1_is_rst", {15'd0, is_rst_IF_ID}, 16'd0);
    step();

    // 2: three-cycle miss at 0x0004
    miss_cnt = 3;
    push(16'h4002, 16'h0006);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_addr_hold", addr_seen, 16'h0004);
      chk("t2_valid_low", {15'd0, valid_IF_ID}, 16'd0);
    end
    step();

    // 3: stall across a completing miss at 0x0006
    miss_cnt = 1;
    push(16'h4003, 16'h0008);
    push(16'h4004, 16'h000A);
    step();
    stall_ID = 1;
    step();
    chk("t3_rd_wait", {15'd0, rd_seen}, 16'd1);
    chk("t3_frozen", instr_IF_ID, 16'h0800);
    step();
    chk("t3_rd_stalled", {15'd0, rd_seen}, 16'd0);
    stall_ID = 0;
    step();
    chk("t3_rd_skid", {15'd0, rd_seen}, 16'd0);
    step();
    chk("t3_addr_next", addr_seen, 16'h0008);

    // 4: redirect to 0x0100 during a miss at 0x000A
    miss_cnt = 5;
    step();
    redirect = 1; redirect_pc = 16'h0100;
    step();
    redirect = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_drain_addr", addr_seen, 16'h000A);
      chk("t4_drain_valid", {15'd0, valid_IF_ID}, 16'd0);
    end
    push(16'h4080, 16'h0102);
    step();
    chk("t4_new_addr", addr_seen, 16'h0100);

    // 5: halt, then redirect to 0x0020
    halt_ID = 1;
    step();
    halt_ID = 0;
    chk("t5_nop", instr_IF_ID, 16'h0800);
    chk("t5_valid", {15'd0, valid_IF_ID}, 16'd0);
    step();
    chk("t5_rd_off", {15'd0, rd_seen}, 16'd0);
    step();
    chk("t5_rd_off2", {15'd0, rd_seen}, 16'd0);
    redirect = 1; redirect_pc = 16'h0020;
    step();
    redirect = 0;
    push(16'h4010, 16'h0022);
    step();
    chk("t5_resume_addr", addr_seen, 16'h0020);

    // 6: asynchronous reset mid-miss, then PC wrap
    miss_cnt = 10;
    step();
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_instr", instr_IF_ID, 16'h0800);
    chk("t6_rst_pc2", pc2_IF_ID, 16'h0000);
    chk("t6_rst_is_rst", {15'd0, is_rst_IF_ID}, 16'd1);
    chk("t6_rst_rd", {15'd0, imem_rd}, 16'd0);
    @(negedge clk);
    miss_cnt = 0;
    rst = 1'b0;
    redirect = 1; redirect_pc = 16'hFFFE;
    step();
    redirect = 0;
    chk("t6_drop_valid", {15'd0, valid_IF_ID}, 16'd0);
    push(16'hBFFF, 16'h0000);
    push(16'h4000, 16'h0002);
    step();
    chk("t6_wrap_addr", addr_seen, 16'hFFFE);
    step();
    chk("t6_after_wrap", addr_seen, 16'h0000);

    chk("sb_empty", exp_q.size()[15:0], 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
